// File: rtl/dummy_dut_17_pkg.sv
// Shared constants for the lab-17 multiply sequencer: storage geometry,
// operand/result addresses and the PC phase boundaries of the fixed program.
package dummy_dut_17_pkg;
  localparam int DW        = 8;
  localparam int MEM_DEPTH = 256;
  localparam int NREGS     = 16;
  localparam int MEM_AW    = $clog2(MEM_DEPTH);
  localparam int RF_AW     = $clog2(NREGS);

  localparam logic [7:0] HALT_PC     = 8'd26;

  localparam logic [7:0] ADDR_A_HI   = 8'd1;
  localparam logic [7:0] ADDR_A_LO   = 8'd2;
  localparam logic [7:0] ADDR_B_HI   = 8'd3;
  localparam logic [7:0] ADDR_B_LO   = 8'd4;
  localparam logic [7:0] ADDR_P_HI   = 8'd5;
  localparam logic [7:0] ADDR_P_MH   = 8'd6;
  localparam logic [7:0] ADDR_P_ML   = 8'd7;
  localparam logic [7:0] ADDR_P_LO   = 8'd8;

  localparam logic [7:0] LOAD_END    = 8'd3;
  localparam logic [7:0] PREP        = 8'd4;
  localparam logic [7:0] MUL_FIRST   = 8'd5;
  localparam logic [7:0] MUL_LAST    = 8'd20;
  localparam logic [7:0] SIGN        = 8'd21;
  localparam logic [7:0] STORE_FIRST = 8'd22;
endpackage

// File: rtl/dummy_dut_17_data_mem.sv
// Data memory: combinational read, synchronous write, deliberately unreset so
// contents preloaded while the core is held in reset survive.
module data_mem
  import dummy_dut_17_pkg::*;
(
  input  logic              clk_i,
  input  logic              we_i,
  input  logic [MEM_AW-1:0] waddr_i,
  input  logic [DW-1:0]     wdata_i,
  input  logic [MEM_AW-1:0] raddr_i,
  output logic [DW-1:0]     rdata_o
);
  logic [DW-1:0] my_memory [0:MEM_DEPTH-1];

  always_ff @(posedge clk_i) begin
    if (we_i) my_memory[waddr_i] <= wdata_i;
  end

  assign rdata_o = my_memory[raddr_i];
endmodule

// File: rtl/dummy_dut_17_reg_file.sv
// Register file: one synchronous write port and four combinational read
// ports so both 16-bit operands can be read in the same cycle. No reset.
module reg_file
  import dummy_dut_17_pkg::*;
(
  input  logic             clk_i,
  input  logic             we_i,
  input  logic [RF_AW-1:0] waddr_i,
  input  logic [DW-1:0]    wdata_i,
  input  logic [RF_AW-1:0] raddr0_i,
  input  logic [RF_AW-1:0] raddr1_i,
  input  logic [RF_AW-1:0] raddr2_i,
  input  logic [RF_AW-1:0] raddr3_i,
  output logic [DW-1:0]    rdata0_o,
  output logic [DW-1:0]    rdata1_o,
  output logic [DW-1:0]    rdata2_o,
  output logic [DW-1:0]    rdata3_o
);
  logic [DW-1:0] registers [0:NREGS-1];

  always_ff @(posedge clk_i) begin
    if (we_i) registers[waddr_i] <= wdata_i;
  end

  assign rdata0_o = registers[raddr0_i];
  assign rdata1_o = registers[raddr1_i];
  assign rdata2_o = registers[raddr2_i];
  assign rdata3_o = registers[raddr3_i];
endmodule

// File: rtl/dummy_dut_17.sv
// Lab-17 stand-in processor: a fixed PC-driven program that loads two signed
// 16-bit operands, multiplies them by sign-magnitude shift-add and stores P.
module dummy_dut_17
  import dummy_dut_17_pkg::*;
(
  input  logic CLK,
  input  logic start,
  output logic halt
);
  localparam logic [RF_AW-1:0] RA_A_HI = ADDR_A_HI[RF_AW-1:0];
  localparam logic [RF_AW-1:0] RA_A_LO = ADDR_A_LO[RF_AW-1:0];
  localparam logic [RF_AW-1:0] RA_B_HI = ADDR_B_HI[RF_AW-1:0];
  localparam logic [RF_AW-1:0] RA_B_LO = ADDR_B_LO[RF_AW-1:0];

  logic [7:0]  PC, pc_d;
  logic [15:0] mcand_q, mcand_d;
  logic [15:0] mplier_q, mplier_d;
  logic        neg_q, neg_d;
  logic [31:0] acc_q, acc_d;

  logic              mem_we;
  logic [MEM_AW-1:0] mem_waddr, mem_raddr;
  logic [DW-1:0]     mem_wdata, mem_rdata;
  logic              rf_we;
  logic [RF_AW-1:0]  rf_waddr;
  logic [DW-1:0]     rf_wdata;
  logic [DW-1:0]     rf_a_hi, rf_a_lo, rf_b_hi, rf_b_lo;

  logic signed [15:0] op_a, op_b;
  logic [3:0]         step;
  logic [1:0]         store_idx;
  logic [DW-1:0]      res_byte;

  function automatic logic [15:0] mag16(input logic signed [15:0] v);
    // -(-32768) wraps back to 16'h8000, which is exactly 32768 unsigned.
    return v[15] ? 16'(-v) : 16'(v);
  endfunction

  function automatic logic [31:0] neg32(input logic [31:0] v);
    return ~v + 32'd1;
  endfunction

  data_mem data_mem1 (
    .clk_i   (CLK),
    .we_i    (mem_we),
    .waddr_i (mem_waddr),
    .wdata_i (mem_wdata),
    .raddr_i (mem_raddr),
    .rdata_o (mem_rdata)
  );

  reg_file reg_file1 (
    .clk_i    (CLK),
    .we_i     (rf_we),
    .waddr_i  (rf_waddr),
    .wdata_i  (rf_wdata),
    .raddr0_i (RA_A_HI),
    .raddr1_i (RA_A_LO),
    .raddr2_i (RA_B_HI),
    .raddr3_i (RA_B_LO),
    .rdata0_o (rf_a_hi),
    .rdata1_o (rf_a_lo),
    .rdata2_o (rf_b_hi),
    .rdata3_o (rf_b_lo)
  );

  assign op_a      = {rf_a_hi, rf_a_lo};
  assign op_b      = {rf_b_hi, rf_b_lo};
  assign step      = PC[3:0] - MUL_FIRST[3:0];
  assign store_idx = PC[1:0] - STORE_FIRST[1:0];
  assign halt      = (PC == HALT_PC);

  always_comb begin
    case (store_idx)
      2'd0:    res_byte = acc_q[31:24];
      2'd1:    res_byte = acc_q[23:16];
      2'd2:    res_byte = acc_q[15:8];
      default: res_byte = acc_q[7:0];
    endcase
  end

  // Program decode: one action per PC value.
  always_comb begin
    pc_d      = (PC < HALT_PC) ? PC + 8'd1 : PC;
    mcand_d   = mcand_q;
    mplier_d  = mplier_q;
    neg_d     = neg_q;
    acc_d     = acc_q;
    mem_raddr = PC + 8'd1;
    mem_we    = 1'b0;
    mem_waddr = ADDR_P_HI + {6'd0, store_idx};
    mem_wdata = res_byte;
    rf_we     = 1'b0;
    rf_waddr  = mem_raddr[RF_AW-1:0];
    rf_wdata  = mem_rdata;

    if (PC <= LOAD_END) begin
      rf_we = 1'b1;
    end else if (PC == PREP) begin
      mcand_d  = mag16(op_a);
      mplier_d = mag16(op_b);
      neg_d    = op_a[15] ^ op_b[15];
      acc_d    = 32'd0;
    end else if (PC >= MUL_FIRST && PC <= MUL_LAST) begin
      if (mplier_q[step]) acc_d = acc_q + ({16'd0, mcand_q} << step);
    end else if (PC == SIGN) begin
      if (neg_q) acc_d = neg32(acc_q);
    end else if (PC >= STORE_FIRST && PC < HALT_PC) begin
      mem_we   = 1'b1;
      rf_we    = 1'b1;
      rf_waddr = mem_waddr[RF_AW-1:0];
      rf_wdata = res_byte;
    end
  end

  always_ff @(posedge CLK or posedge start) begin
    if (start) begin
      PC       <= 8'd0;
      mcand_q  <= 16'd0;
      mplier_q <= 16'd0;
      neg_q    <= 1'b0;
      acc_q    <= 32'd0;
    end else begin
      PC       <= pc_d;
      mcand_q  <= mcand_d;
      mplier_q <= mplier_d;
      neg_q    <= neg_d;
      acc_q    <= acc_d;
    end
  end
endmodule

// File: tb/tb_dummy_dut_17.sv
// Directed bench for dummy_dut_17: preloads operands hierarchically, runs the
// program and compares stored products against hand-computed constants.
module tb_dummy_dut_17;
  logic CLK = 1'b0;
  logic start = 1'b0;
  logic halt;

  int n_cmp = 0;
  int n_bad = 0;

  dummy_dut_17 dut (
    .CLK   (CLK),
    .start (start),
    .halt  (halt)
  );

  always #5 CLK = ~CLK;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  function automatic logic [7:0] fill_pat(input int i);
    return 8'(i) ^ 8'hA5;
  endfunction

  task automatic preload(input logic [15:0] a, input logic [15:0] b);
    dut.data_mem1.my_memory[1] = a[15:8];
    dut.data_mem1.my_memory[2] = a[7:0];
    dut.data_mem1.my_memory[3] = b[15:8];
    dut.data_mem1.my_memory[4] = b[7:0];
  endtask

  task automatic wait_halt(input string tag, output int cycles);
    cycles = 0;
    for (int k = 0; k < 40; k++) begin
      @(posedge CLK);
      #1;
      cycles++;
      if (halt) break;
    end
    chk({tag, "_cycles"}, 32'(cycles), 32'd26);
    chk({tag, "_pc"}, {24'd0, dut.PC}, 32'd26);
  endtask

  task automatic chk_result(input string tag, input logic [31:0] exp);
    chk({tag, "_mem"}, {dut.data_mem1.my_memory[5], dut.data_mem1.my_memory[6],
                        dut.data_mem1.my_memory[7], dut.data_mem1.my_memory[8]}, exp);
    chk({tag, "_regs"}, {dut.reg_file1.registers[5], dut.reg_file1.registers[6],
                         dut.reg_file1.registers[7], dut.reg_file1.registers[8]}, exp);
  endtask

  task automatic reassert_start(input string tag);
    @(negedge CLK);
    start = 1'b1;
    #1;
    chk({tag, "_rst_pc"}, {24'd0, dut.PC}, 32'd0);
    chk({tag, "_rst_halt"}, {31'd0, halt}, 32'd0);
  endtask

  task automatic run_mul(input string tag, input logic [15:0] a, input logic [15:0] b,
                         input logic [31:0] exp);
    int cyc;
    preload(a, b);
    @(negedge CLK);
    start = 1'b0;
    wait_halt(tag, cyc);
    chk_result(tag, exp);
    reassert_start(tag);
  endtask

  initial begin
    int cyc;
    int nbad_mem;
    #2 start = 1'b1;
    for (int i = 0; i < 256; i++) dut.data_mem1.my_memory[i] = fill_pat(i);
    for (int i = 0; i < 16; i++) dut.reg_file1.registers[i] = 8'h00;
    repeat (2) @(posedge CLK);
    #1;
    chk("reset_pc", {24'd0, dut.PC}, 32'd0);
    chk("reset_halt", {31'd0, halt}, 32'd0);

    // 3*5, including halt persistence after completion.
    preload(16'd3, 16'd5);
    @(negedge CLK);
    start = 1'b0;
    wait_halt("p3x5", cyc);
    chk_result("p3x5", 32'h0000_000F);
    repeat (3) @(posedge CLK);
    #1;
    chk("p3x5_halt_hold", {31'd0, halt}, 32'd1);
    chk("p3x5_pc_hold", {24'd0, dut.PC}, 32'd26);
    reassert_start("p3x5");

    run_mul("m1x1",      16'hFFFF, 16'h0001, 32'hFFFF_FFFF);
    run_mul("min_x_min", 16'h8000, 16'h8000, 32'h4000_0000);
    run_mul("max_x_min", 16'h7FFF, 16'h8000, 32'hC000_8000);
    run_mul("zero_neg",  16'h0000, 16'hFFFB, 32'h0000_0000);

    // Abort mid-run at PC=10, then rerun from the same memory contents.
    preload(16'h1234, 16'h0056);
    @(negedge CLK);
    start = 1'b0;
    for (int k = 0; k < 20; k++) begin
      @(posedge CLK);
      #1;
      if (dut.PC == 8'd10) break;
    end
    chk("abort_reach_pc10", {24'd0, dut.PC}, 32'd10);
    start = 1'b1;
    #1;
    chk("abort_async_pc", {24'd0, dut.PC}, 32'd0);
    chk("abort_async_halt", {31'd0, halt}, 32'd0);
    repeat (2) @(posedge CLK);
    #1;
    chk("abort_hold_pc", {24'd0, dut.PC}, 32'd0);
    chk("abort_untouched_p", {dut.data_mem1.my_memory[5], dut.data_mem1.my_memory[6],
                              dut.data_mem1.my_memory[7], dut.data_mem1.my_memory[8]},
        32'h0000_0000);
    @(negedge CLK);
    start = 1'b0;
    wait_halt("rerun", cyc);
    chk_result("rerun", 32'h0006_1D78);

    nbad_mem = 0;
    if (dut.data_mem1.my_memory[0] !== fill_pat(0)) nbad_mem++;
    for (int i = 9; i < 256; i++)
      if (dut.data_mem1.my_memory[i] !== fill_pat(i)) nbad_mem++;
    chk("untouched_addrs", 32'(nbad_mem), 32'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
